seg7_scan_ctrl: RTL and testbench
=================================

SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001: Parameter DIV, default 100000, clock cycles per digit slot (1 kHz slot rate at 100 MHz); legal range 2..2^20.
REQ-002: Parameter DEAD, default 1000, blanking cycles at the start of each slot (anti-ghosting); legal range 0..DIV-1.
REQ-003: clk  input  1  system clock, 100 MHz; the only clock.
REQ-004: rst_n  input  1  reset, synchronous to clk, active-low.
REQ-005: data  input  32  eight 4-bit codes; nibble i (data[4i+3:4i]) drives digit position i; position 0 is rightmost.
REQ-006: digit_en  input  8  per-position enable; 0 = position always dark.
REQ-007: blank_lz  input  1  1 = leading-zero blanking on.
REQ-008: load  input  1  1-cycle strobe; captures data, digit_en and blank_lz into the pending register.
REQ-009: an  output  8  anode selects, active-low, one-hot-low or all-high; wires to AN.
REQ-010: digit  output  4  code for the selected position; feeds Hex7Seg.digit.
REQ-011: frame_done  output  1  1-cycle pulse at each frame boundary.

Function
REQ-012: Slot counter cnt counts 0..DIV-1 and wraps; scan index idx advances by 1 when cnt=DIV-1, wrapping 7->0.
REQ-013: Frame boundary is the cycle where cnt=DIV-1 and idx=7.
REQ-014: Block holds two register sets: pending (loaded by load) and active (drives the display).
REQ-015: On load=1, pending takes data/digit_en/blank_lz the next edge; a later load overwrites earlier unapplied loads.
REQ-016: At a frame boundary, active takes the pending value held before that edge; load in the same cycle updates pending only, applied at the next boundary.
REQ-017: Active updates only at frame boundaries; no mid-frame change is visible on an/digit.
REQ-018: Position i is blanked if digit_en[i]=0, or if blank_lz=1, i!=0, and every active nibble j>=i equals 0.
REQ-019: an and digit are registered; each reflects idx, cnt and active from the previous cycle (1-cycle latency).
REQ-020: an = all-high when cnt<DEAD or position idx is blanked; otherwise an[idx]=0 and all other bits 1.
REQ-021: digit = active nibble idx every cycle, including dark cycles; it is never forced to zero.
REQ-022: frame_done is registered and asserts for exactly one cycle, the cycle after each frame boundary.
REQ-023: Nibble values 10..15 are passed through unchanged; no BCD validity check.
REQ-024: With DEAD=0, no dead-time blanking occurs.

Reset
REQ-025: While rst_n=0 at an edge: cnt=0, idx=0, pending=0, active=0, an=8'hFF, digit=0, frame_done=0.
REQ-026: Reset overrides load and the frame-boundary transfer in the same cycle.
REQ-027: Reset mid-frame discards pending and active; the display stays dark until a load plus one frame boundary.
REQ-028: After reset release, the first frame_done occurs 8*DIV cycles later.

Verification (DIV=8, DEAD=2)
REQ-029: Reset release, no load -> an=8'hFF for 3 full frames; frame_done pulses every 64 cycles.
REQ-030: load data=32'h76543210, digit_en=8'hFF, blank_lz=0 -> after the next boundary, each slot shows an bit i low on cycles 2..7 of the slot, digit=i, and 2 dark cycles per slot.
REQ-031: data=32'h00000450, blank_lz=1, en=8'hFF -> positions 0..2 lit (digits 0,5,4); positions 3..7 dark; with data=0, only position 0 is lit (digit 0).
REQ-032: load asserted on the boundary cycle with new data -> old pending shown for the next frame; new data shown one frame later.
REQ-033: Three loads within one frame -> only the last is displayed after the boundary; no mid-frame change on digit.
REQ-034: rst_n=0 for 1 cycle at idx=4 -> an=8'hFF next cycle; cnt and idx restart at 0; display stays dark until a reload.

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// Eight-position multiplexed 7-segment scan controller with a double-buffered
// display value, dead-time blanking between slots and leading-zero suppression.
module seg7_scan_ctrl #(
    parameter int DIV  = 100000,
    parameter int DEAD = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] data,
    input  logic [7:0]  digit_en,
    input  logic        blank_lz,
    input  logic        load,
    output logic [7:0]  an,
    output logic [3:0]  digit,
    output logic        frame_done
);
    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  en;
        logic        blz;
    } disp_t;

    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    disp_t         pend;
    disp_t         act;

    logic          slot_end;
    logic          boundary;
    logic          dead;
    logic [7:0]    nz_upper;
    logic [7:0]    blank;
    logic [7:0]    an_next;
    logic [3:0]    nib;

    assign slot_end = (cnt == CNT_MAX);
    assign boundary = slot_end && (idx == 3'd7);
    assign dead     = {{(32-CW){1'b0}}, cnt} < $unsigned(DEAD);
    assign nib      = act.data[idx*4 +: 4];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt  <= '0;
            idx  <= '0;
            pend <= '0;
            act  <= '0;
        end else begin
            cnt <= slot_end ? '0 : cnt + 1'b1;
            if (slot_end) idx <= idx + 3'd1;
            if (load) pend <= '{data: data, en: digit_en, blz: blank_lz};
            // active takes the pending value held before this edge
            if (boundary) act <= pend;
        end
    end

    // nz_upper[i]: some active nibble at position i or above is non-zero
    always_comb begin
        nz_upper = '0;
        blank    = '0;
        for (int i = 0; i < 8; i++) begin
            nz_upper[i] = (act.data >> (4 * i)) != 32'd0;
            blank[i]    = !act.en[i] || (act.blz && (i != 0) && !nz_upper[i]);
        end
    end

    always_comb begin
        an_next = 8'hFF;
        if (!dead && !blank[idx]) an_next = ~(8'h01 << idx);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            an         <= 8'hFF;
            digit      <= '0;
            frame_done <= 1'b0;
        end else begin
            an         <= an_next;
            digit      <= nib;
            frame_done <= boundary;
        end
    end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl (DIV=8, DEAD=2): a cycle-level reference
// model queues expected outputs, plus frame-level spot checks.
module tb_seg7_scan_ctrl;
    localparam int DIV  = 8;
    localparam int DEAD = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] data;
    logic [7:0]  digit_en;
    logic        blank_lz;
    logic        load;
    logic [7:0]  an;
    logic [3:0]  digit;
    logic        frame_done;

    seg7_scan_ctrl #(.DIV(DIV), .DEAD(DEAD)) dut (
        .clk(clk), .rst_n(rst_n), .data(data), .digit_en(digit_en),
        .blank_lz(blank_lz), .load(load), .an(an), .digit(digit),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] an;
        logic [3:0] digit;
        logic       fd;
    } exp_t;

    exp_t exp_q[$];
    int checks   = 0;
    int failures = 0;

    // reference model state
    int          m_cnt, m_idx;
    logic [31:0] m_pd, m_ad;
    logic [7:0]  m_pe, m_ae;
    logic        m_pb, m_ab;

    // frame statistics
    logic [7:0] lit_mask;
    int lit_cnt, fd_cnt, nsteps, first_fd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_blank(input int i);
        if (!m_ae[i]) return 1'b1;
        if (m_ab && i != 0) begin
            for (int j = i; j < 8; j++)
                if (m_ad[4*j +: 4] != 4'd0) return 1'b0;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic clear_stats();
        lit_mask = 8'h00;
        lit_cnt  = 0;
        fd_cnt   = 0;
        nsteps   = 0;
        first_fd = -1;
    endtask

    task automatic step();
        exp_t e;
        exp_t g;
        bit bnd;
        if (!rst_n) begin
            e = '{an: 8'hFF, digit: 4'h0, fd: 1'b0};
            m_cnt = 0; m_idx = 0;
            m_pd = '0; m_pe = '0; m_pb = 1'b0;
            m_ad = '0; m_ae = '0; m_ab = 1'b0;
        end else begin
            bnd     = (m_cnt == DIV - 1) && (m_idx == 7);
            e.an    = (m_cnt < DEAD || m_blank(m_idx)) ? 8'hFF : ~(8'h01 << m_idx);
            e.digit = m_ad[4*m_idx +: 4];
            e.fd    = bnd;
            if (bnd) begin m_ad = m_pd; m_ae = m_pe; m_ab = m_pb; end
            if (load) begin m_pd = data; m_pe = digit_en; m_pb = blank_lz; end
            if (m_cnt == DIV - 1) begin
                m_cnt = 0;
                m_idx = (m_idx + 1) % 8;
            end else m_cnt++;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        g = exp_q.pop_front();
        chk("an", {24'h0, an}, {24'h0, g.an});
        chk("digit", {28'h0, digit}, {28'h0, g.digit});
        chk("frame_done", {31'h0, frame_done}, {31'h0, g.fd});
        nsteps++;
        lit_mask |= ~an;
        if (an != 8'hFF) lit_cnt++;
        if (frame_done) begin
            fd_cnt++;
            if (first_fd < 0) first_fd = nsteps;
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic do_load(input logic [31:0] d, input logic [7:0] en, input logic blz);
        data = d; digit_en = en; blank_lz = blz; load = 1'b1;
        step();
        load = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; load = 1'b0; data = '0; digit_en = '0; blank_lz = 1'b0;
        clear_stats();
        run(3);
        chk("rst_an", {24'h0, an}, 32'hFF);
        chk("rst_digit", {28'h0, digit}, 32'h0);
        chk("rst_fd", {31'h0, frame_done}, 32'h0);

        // three dark frames after release, first frame_done 8*DIV cycles later
        rst_n = 1'b1;
        clear_stats();
        run(192);
        chk("idle_fd_cnt", fd_cnt, 3);
        chk("idle_first_fd", first_fd, 64);
        chk("idle_lit_mask", {24'h0, lit_mask}, 32'h0);

        // full count pattern, no blanking: 6 lit cycles per slot
        do_load(32'h76543210, 8'hFF, 1'b0);
        run(63);
        clear_stats();
        run(64);
        chk("cnt_lit_mask", {24'h0, lit_mask}, 32'hFF);
        chk("cnt_lit_cycles", lit_cnt, 48);
        chk("cnt_fd_cnt", fd_cnt, 1);

        // leading-zero suppression keeps positions 0..2
        do_load(32'h00000450, 8'hFF, 1'b1);
        run(63);
        clear_stats();
        run(64);
        chk("lz_lit_mask", {24'h0, lit_mask}, 32'h07);
        chk("lz_lit_cycles", lit_cnt, 18);

        // all-zero data: only position 0 survives
        do_load(32'h0, 8'hFF, 1'b1);
        run(63);
        clear_stats();
        run(64);
        chk("zero_lit_mask", {24'h0, lit_mask}, 32'h01);
        chk("zero_lit_cycles", lit_cnt, 6);

        // load on the boundary cycle lands one frame later
        do_load(32'h11111111, 8'hFF, 1'b0);
        run(62);
        do_load(32'h22222222, 8'hFF, 1'b0);
        run(32);
        chk("bnd_old_digit", {28'h0, digit}, 32'h1);
        run(64);
        chk("bnd_new_digit", {28'h0, digit}, 32'h2);
        run(32);

        // three loads in one frame: no mid-frame change, last one wins
        do_load(32'h33333333, 8'hFF, 1'b0);
        run(5);
        do_load(32'h44444444, 8'hFF, 1'b0);
        run(20);
        chk("multi_mid_digit", {28'h0, digit}, 32'h2);
        do_load(32'h55555555, 8'hF0, 1'b0);
        run(36);
        clear_stats();
        run(64);
        chk("multi_new_digit", {28'h0, digit}, 32'h5);
        chk("multi_lit_mask", {24'h0, lit_mask}, 32'hF0);

        // one-cycle reset at idx=4 discards everything
        run(32);
        rst_n = 1'b0;
        step();
        chk("mid_rst_an", {24'h0, an}, 32'hFF);
        rst_n = 1'b1;
        clear_stats();
        run(128);
        chk("post_rst_lit_mask", {24'h0, lit_mask}, 32'h0);
        chk("post_rst_fd_cnt", fd_cnt, 2);
        chk("post_rst_first_fd", first_fd, 64);
        do_load(32'h89ABCDEF, 8'hFF, 1'b0);
        run(63);
        clear_stats();
        run(64);
        chk("reload_lit_mask", {24'h0, lit_mask}, 32'hFF);
        chk("queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
